// File: rtl/register_file.sv
// RV32 integer register file: two combinational read ports, one synchronous write port, x0 reads zero.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards a same-cycle write to the read ports before the edge commits it.
module register_file #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  input  logic [WORD_SIZE-1:0]  write_data,
  output logic [WORD_SIZE-1:0]  read_data1,
  output logic [WORD_SIZE-1:0]  read_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_SIZE-1:0]  regs [DEPTH];
  logic                  commit;
  logic [ADDR_WIDTH-1:0] read_addr [2];
  logic [WORD_SIZE-1:0]  read_data [2];

  // x0 is never written, so its slot stays at the reset value
  assign commit = write_enable && (write_addr != '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[write_addr] <= write_data;
    end
  end

  assign read_addr[0] = read_addr1;
  assign read_addr[1] = read_addr2;
  assign read_data1   = read_data[0];
  assign read_data2   = read_data[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read_port
      always_comb begin
        read_data[gi] = '0;
        if (read_addr[gi] != '0) begin
`ifdef REGFILE_WRITE_BYPASS_EN
          // reset_n gates forwarding because reset drops the pending write
          if (commit && reset_n && (write_addr == read_addr[gi])) begin
            read_data[gi] = write_data;
          end else begin
            read_data[gi] = regs[read_addr[gi]];
          end
`else
          read_data[gi] = regs[read_addr[gi]];
`endif
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected reads, a negedge monitor checks them.
module tb_register_file;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  typedef struct {
    string       name;
    bit          port;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int total = 0;
  int bad   = 0;

  register_file #(.WORD_SIZE(32), .ADDR_WIDTH(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .read_addr1   (read_addr1),
    .read_addr2   (read_addr2),
    .write_data   (write_data),
    .read_data1   (read_data1),
    .read_data2   (read_data2)
  );

  always #5 clock = ~clock;

  // Monitor: read ports are valid every cycle, sample at mid-cycle
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      sb_entry_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = e.port ? read_data2 : read_data1;
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s port%0d: got %h expected %h", e.name, e.port + 1, act, e.exp);
      end else begin
        $display("ok   %s port%0d: %h", e.name, e.port + 1, act);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_rd(input string name, input bit port, input logic [31:0] exp);
    sb_entry_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs; expectations queued afterwards are for this cycle (before the edge)
  task automatic drive(input logic rst_n, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    reset_n      = rst_n;
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    read_addr1   = ra1;
    read_addr2   = ra2;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pattern(input int i);
    return (32'h01010101 * i) ^ 32'h5A000000;
  endfunction

  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    // Before any reset only x0 has a defined value
    expect_rd("x0_pre_reset", 0, 32'h0);
    expect_rd("x0_pre_reset", 1, 32'h0);
    next_cycle();

    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      expect_rd($sformatf("reset_sweep_%0d", i), 0, 32'h0);
      expect_rd($sformatf("reset_sweep_%0d", 31 - i), 1, 32'h0);
      next_cycle();
    end

    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    expect_rd("write_x5", 0, 32'hDEADBEEF);
    expect_rd("write_x5", 1, 32'hDEADBEEF);
    next_cycle();

    drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    expect_rd("x0_write_same_cycle", 0, 32'h0);
    expect_rd("x0_write_same_cycle", 1, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    expect_rd("x0_after_write", 0, 32'h0);
    expect_rd("x5_unchanged", 1, 32'hDEADBEEF);
    next_cycle();

    drive(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd7, 32'hCAFEBABE, 5'd7, 5'd7);
    expect_rd("we0_x7_before", 0, 32'h12345678);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
    expect_rd("we0_x7_after", 0, 32'h12345678);
    expect_rd("we0_x5_after", 1, 32'hDEADBEEF);
    next_cycle();

    drive(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0);
    next_cycle();
    drive(1'b0, 1'b1, 5'd3, 32'h00000001, 5'd3, 5'd5);
    // Contents stay readable while reset is low, until the edge
    expect_rd("rst_prio_x3_before", 0, 32'hA5A5A5A5);
    expect_rd("rst_prio_x5_before", 1, 32'hDEADBEEF);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
    expect_rd("rst_prio_x3_after", 0, 32'h0);
    expect_rd("rst_clears_x5", 1, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    expect_rd("rst_clears_x7", 0, 32'h0);
    next_cycle();

    drive(1'b1, 1'b1, 5'd9, 32'h11, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 1'b1, 5'd9, 32'h22, 5'd9, 5'd9);
    expect_rd("bypass_before_edge", 0, BYPASS ? 32'h22 : 32'h11);
    expect_rd("bypass_before_edge", 1, BYPASS ? 32'h22 : 32'h11);
    next_cycle();
    drive(1'b1, 1'b1, 5'd0, 32'h33, 5'd9, 5'd0);
    expect_rd("bypass_after_edge", 0, 32'h22);
    expect_rd("bypass_x0_write", 1, 32'h0);
    next_cycle();

    // Distinct pattern in every register, then read back crossed pairs
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b1, 5'(i), pattern(i), 5'd0, 5'd0);
      next_cycle();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      expect_rd($sformatf("pattern_x%0d", i), 0, (i == 0) ? 32'h0 : pattern(i));
      expect_rd($sformatf("pattern_x%0d", 31 - i), 1, (i == 31) ? 32'h0 : pattern(31 - i));
      next_cycle();
    end

    begin
      int waited = 0;
      while (sb.size() > 0 && waited < 10) begin
        next_cycle();
        waited++;
      end
      if (sb.size() > 0) begin
        $display("FAIL drain: got %0d unchecked expected 0", sb.size());
        bad = bad + sb.size();
        total = total + sb.size();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
